// File: rtl/multicyc_exec_pkg.sv
// Shared types for the multi-cycle HI/LO unit: opcodes, request/response, FSM states.
package multicyc_exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL,
    OP_DIV, OP_DIVU
  } oper_t;

  typedef struct packed {
    oper_t       op;
    logic        is_multicyc;
    logic [63:0] hilo;
    logic [31:0] reg0;
    logic [31:0] reg1;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [63:0] hilo;
  } multicyc_resp_t;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} multicyc_state_t;

  localparam int MULTICYC_DIV_ITERS = 32;

  function automatic int div_iters(int bits_per_cyc);
    return 32 / bits_per_cyc;
  endfunction

  function automatic logic is_mul_op(oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
  endfunction

  function automatic logic is_div_op(oper_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic [31:0] abs32(logic sgn, logic [31:0] x);
    return (sgn && x[31]) ? 32'(-x) : x;
  endfunction

endpackage

// File: rtl/multicyc_exec_div.sv
// Iterative restoring divider on magnitudes; sign fix-up folded into the last iteration.
module multicyc_div
  import multicyc_exec_pkg::*;
#(
  parameter int DIV_BITS_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  localparam int ITERS = div_iters(DIV_BITS_CYC);
  localparam int CW    = $clog2(ITERS);

  logic          running, neg_q, neg_r;
  logic [CW-1:0] cnt;
  logic [31:0]   r, q, d, r_n, q_n;
  logic [32:0]   tr;

  // Divisor 0 always passes the compare, giving q=all ones and r=|dividend|.
  always_comb begin
    r_n = r;
    q_n = q;
    tr  = '0;
    for (int i = 0; i < DIV_BITS_CYC; i++) begin
      tr = {r_n, q_n[31]};
      if (tr >= {1'b0, d}) begin
        r_n = 32'(tr - {1'b0, d});
        q_n = {q_n[30:0], 1'b1};
      end else begin
        r_n = tr[31:0];
        q_n = {q_n[30:0], 1'b0};
      end
    end
  end

  assign done = running && (cnt == '0);
  assign quot = neg_q ? 32'(-q_n) : q_n;
  assign rem  = neg_r ? 32'(-r_n) : r_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      r       <= '0;
      q       <= '0;
      d       <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (kill) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(ITERS - 1);
      r       <= '0;
      q       <= abs32(signed_op, dividend);
      d       <= abs32(signed_op, divisor);
      neg_q   <= signed_op && (dividend[31] ^ divisor[31]);
      neg_r   <= signed_op && dividend[31];
    end else if (running) begin
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) running <= 1'b0;
    end
  end

endmodule

// File: rtl/multicyc_exec.sv
// Multi-cycle HI/LO unit: pipelined multiply/accumulate and iterative divide beside EX.
module multicyc_exec
  import multicyc_exec_pkg::*;
#(
  parameter int MUL_LATENCY  = 3,
  parameter int DIV_BITS_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  multicyc_req_t  req,
  input  logic           resp_ack,
  output multicyc_resp_t resp,
  output logic           busy
);
  multicyc_state_t state, nxt;
  logic [1:0]  cnt;
  oper_t       op_q;
  logic [31:0] rs_q, rt_q, div_quot, div_rem;
  logic [63:0] acc_q, hilo_q, mul_res;
  logic        stale, stale_eff, accept, div_start, div_done, sgn;
  logic signed [32:0] ma, mb;
  logic [63:0] p_pipe [MUL_LATENCY];

  // A request held unchanged after its ack must not be executed twice.
  assign stale_eff = stale && req.is_multicyc && (req.op == op_q)
                     && (req.reg0 == rs_q) && (req.reg1 == rt_q);
  assign accept = (state == IDLE) && req.is_multicyc && !flush && !stale_eff
                  && (is_mul_op(req.op) || is_div_op(req.op));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (flush) nxt = IDLE;
    else begin
      case (state)
        IDLE:     if (accept) nxt = is_div_op(req.op) ? DIV_BUSY : MUL_BUSY;
        MUL_BUSY: if (cnt == 2'd0) nxt = DONE;
        DIV_BUSY: if (div_done) nxt = DONE;
        DONE:     if (resp_ack) nxt = IDLE;
        default:  nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    resp.valid = (state == DONE);
    resp.ready = (state == DONE);
    resp.hilo  = hilo_q;
    busy       = (state == MUL_BUSY) || (state == DIV_BUSY);
  end

  assign sgn = op_q inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL};
  assign ma  = {sgn & rs_q[31], rs_q};
  assign mb  = {sgn & rt_q[31], rt_q};
  assign p_pipe[0] = 64'(ma) * 64'(mb);

  // Operands are frozen after accept, so the retiming pipe can shift freely.
  for (genvar k = 1; k < MUL_LATENCY; k++) begin : g_mpipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) p_pipe[k] <= '0;
      else     p_pipe[k] <= p_pipe[k-1];
    end
  end

  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc_q + p_pipe[MUL_LATENCY-1];
      OP_MSUB, OP_MSUBU: mul_res = acc_q - p_pipe[MUL_LATENCY-1];
      default:           mul_res = p_pipe[MUL_LATENCY-1];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= OP_ADD;
      rs_q      <= '0;
      rt_q      <= '0;
      acc_q     <= '0;
      hilo_q    <= '0;
      stale     <= 1'b0;
      div_start <= 1'b0;
    end else begin
      div_start <= accept && is_div_op(req.op);
      if (accept) begin
        op_q  <= req.op;
        rs_q  <= req.reg0;
        rt_q  <= req.reg1;
        acc_q <= req.hilo;
        cnt   <= 2'(MUL_LATENCY - 1);
      end else if (state == MUL_BUSY && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (!flush && state == MUL_BUSY && cnt == 2'd0) hilo_q <= mul_res;
      if (!flush && state == DIV_BUSY && div_done)    hilo_q <= {div_rem, div_quot};
      if (flush)                            stale <= 1'b0;
      else if (state == DONE && resp_ack)   stale <= 1'b1;
      else if (!stale_eff)                  stale <= 1'b0;
    end
  end

  multicyc_div #(.DIV_BITS_CYC(DIV_BITS_CYC)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (flush),
    .signed_op(op_q == OP_DIV),
    .dividend (rs_q),
    .divisor  (rt_q),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

endmodule
